// File: rtl/stream_packetizer_pkg.sv
// Shared definitions for the stream packetizer: framing FSM states and the
// default header byte.
package stream_packetizer_pkg;

    typedef enum logic [1:0] {
        S_HDR,
        S_PAY,
        S_CSUM
    } state_t;

    localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

endpackage

// File: rtl/stream_packetizer_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head output, used as the
// packetizer input buffer.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (r_wrPtr == r_rdPtr);
    assign full     = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign head     = r_mem[r_rdPtr[AW-1:0]];
    assign w_doPush = i_push && !full;
    assign w_doPop  = i_pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
            if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/stream_packetizer.sv
// Frames a byte stream into packets: header byte, PKT_LEN payload bytes, and
// a modulo-256 checksum byte flagged with last_out.
module stream_packetizer
    import stream_packetizer_pkg::*;
#(
    parameter int         PKT_LEN    = 4,
    parameter logic [7:0] HDR_BYTE   = DEFAULT_HDR_BYTE,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [7:0]  data_in,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [7:0]  data_out,
    output logic        last_out,
    output logic [15:0] pkt_count
);

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_csum;
    logic [7:0]  r_byteCnt;
    logic [15:0] r_pktCount;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_xfer;

    // ready_in looks only at FIFO fullness so it never waits on ready_out.
    assign ready_in  = !w_full;
    assign w_push    = valid_in && !w_full;
    assign w_xfer    = valid_out && ready_out;
    assign pkt_count = r_pktCount;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data (data_in),
        .full   (w_full),
        .empty  (w_empty),
        .head   (w_head)
    );

    always_comb begin
        w_nextState = r_state;
        valid_out   = 1'b0;
        data_out    = HDR_BYTE;
        last_out    = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_HDR: begin
                valid_out = !w_empty;
                if (!w_empty && ready_out) w_nextState = S_PAY;
            end
            S_PAY: begin
                valid_out = !w_empty;
                data_out  = w_head;
                if (!w_empty && ready_out) begin
                    w_pop = 1'b1;
                    if (r_byteCnt == 8'(PKT_LEN - 1)) w_nextState = S_CSUM;
                end
            end
            S_CSUM: begin
                valid_out = 1'b1;
                data_out  = r_csum;
                last_out  = 1'b1;
                if (ready_out) w_nextState = S_HDR;
            end
            default: w_nextState = S_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HDR;
            r_csum     <= '0;
            r_byteCnt  <= '0;
            r_pktCount <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_xfer) begin
                case (r_state)
                    S_HDR: begin
                        r_csum    <= '0;
                        r_byteCnt <= '0;
                    end
                    S_PAY: begin
                        r_csum    <= r_csum + w_head;
                        r_byteCnt <= r_byteCnt + 8'd1;
                    end
                    S_CSUM:  r_pktCount <= r_pktCount + 16'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_packetizer.sv
// Directed self-checking bench for stream_packetizer with default parameters
// (PKT_LEN=4, HDR_BYTE=A5, FIFO_DEPTH=4).
module tb_stream_packetizer;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic [7:0]  data_in;
    logic        valid_out;
    logic        ready_out;
    logic [7:0]  data_out;
    logic        last_out;
    logic [15:0] pkt_count;

    int errors = 0;
    int checks = 0;

    // Each captured output transfer is stored as {last_out, data_out}.
    logic [8:0] outQ [$];

    logic [8:0] expBasic [6] = '{9'h0A5, 9'h001, 9'h002, 9'h003, 9'h004, 9'h10A};
    logic [8:0] expWrap  [6] = '{9'h0A5, 9'h0FF, 9'h0FF, 9'h002, 9'h000, 9'h100};
    logic [8:0] expBp    [12] = '{9'h0A5, 9'h011, 9'h022, 9'h033, 9'h044, 9'h1AA,
                                  9'h0A5, 9'h055, 9'h066, 9'h077, 9'h088, 9'h1BA};
    logic [8:0] expPart  [3] = '{9'h0A5, 9'h001, 9'h002};
    logic [8:0] expRst   [6] = '{9'h0A5, 9'h009, 9'h009, 9'h009, 9'h009, 9'h124};
    logic [8:0] expCnt   [6] = '{9'h0A5, 9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 9'h10E};

    stream_packetizer dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .last_out  (last_out),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (valid_out && ready_out) outQ.push_back({last_out, data_out});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        valid_in  = v;
        data_in   = d;
        ready_out = r;
        #1;
    endtask

    task automatic waitOutputs(input string tag, input int n);
        for (int c = 0; c < 200 && outQ.size() < n; c++) @(negedge clk);
        #3;
        checkOutput({tag, "_count"}, 32'(outQ.size()), 32'(n));
    endtask

    function automatic logic [31:0] outAt(input int i);
        if (i < outQ.size()) return 32'(outQ[i]);
        return 32'hDEAD;
    endfunction

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        data_in   = 8'h00;
        ready_out = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_valid_out", 32'(valid_out), 32'd0);
        checkOutput("rst_ready_in",  32'(ready_in),  32'd1);
        checkOutput("rst_last_out",  32'(last_out),  32'd0);
        checkOutput("rst_data_out",  32'(data_out),  32'hA5);
        checkOutput("rst_pkt_count", 32'(pkt_count), 32'd0);

        $display("[TB] basic packet");
        outQ.delete();
        applyStimulus(1'b1, 8'h01, 1'b1);
        applyStimulus(1'b1, 8'h02, 1'b1);
        applyStimulus(1'b1, 8'h03, 1'b1);
        applyStimulus(1'b1, 8'h04, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        waitOutputs("basic", 6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("basic[%0d]", i), outAt(i), 32'(expBasic[i]));
        checkOutput("basic_pkt_count", 32'(pkt_count), 32'd1);

        $display("[TB] checksum wrap");
        outQ.delete();
        applyStimulus(1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b1, 8'h02, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        waitOutputs("wrap", 6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("wrap[%0d]", i), outAt(i), 32'(expWrap[i]));
        checkOutput("wrap_pkt_count", 32'(pkt_count), 32'd2);

        $display("[TB] backpressure and full boundary");
        applyStimulus(1'b1, 8'h11, 1'b0);
        checkOutput("bp_ready_in0", 32'(ready_in), 32'd1);
        applyStimulus(1'b1, 8'h22, 1'b0);
        checkOutput("bp_ready_in1", 32'(ready_in), 32'd1);
        checkOutput("bp_hold_valid1", 32'(valid_out), 32'd1);
        checkOutput("bp_hold_data1",  32'(data_out),  32'hA5);
        applyStimulus(1'b1, 8'h33, 1'b0);
        checkOutput("bp_ready_in2", 32'(ready_in), 32'd1);
        applyStimulus(1'b1, 8'h44, 1'b0);
        checkOutput("bp_ready_in3", 32'(ready_in), 32'd1);
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("bp_ready_in_full", 32'(ready_in), 32'd0);
        checkOutput("bp_hold_data4",    32'(data_out), 32'hA5);
        checkOutput("bp_hold_last4",    32'(last_out), 32'd0);
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("bp_still_full",    32'(ready_in),  32'd0);
        checkOutput("bp_hold_valid5",   32'(valid_out), 32'd1);
        checkOutput("bp_hold_data5",    32'(data_out),  32'hA5);
        outQ.delete();
        applyStimulus(1'b1, 8'h55, 1'b1);
        checkOutput("bp_rel_ready_in", 32'(ready_in), 32'd0);
        checkOutput("bp_rel_hdr",      32'(data_out), 32'hA5);
        applyStimulus(1'b1, 8'h55, 1'b1);
        checkOutput("full_pop_ready_in", 32'(ready_in), 32'd0);
        checkOutput("full_pop_head",     32'(data_out), 32'h11);
        applyStimulus(1'b1, 8'h55, 1'b1);
        checkOutput("full_after_pop_ready_in", 32'(ready_in), 32'd1);
        applyStimulus(1'b1, 8'h66, 1'b1);
        applyStimulus(1'b1, 8'h77, 1'b1);
        applyStimulus(1'b1, 8'h88, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        waitOutputs("bp", 12);
        for (int i = 0; i < 12; i++)
            checkOutput($sformatf("bp[%0d]", i), outAt(i), 32'(expBp[i]));
        checkOutput("bp_pkt_count", 32'(pkt_count), 32'd4);

        $display("[TB] reset mid-packet");
        outQ.delete();
        applyStimulus(1'b1, 8'h01, 1'b1);
        applyStimulus(1'b1, 8'h02, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        waitOutputs("part", 3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("part[%0d]", i), outAt(i), 32'(expPart[i]));
        applyStimulus(1'b1, 8'h03, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("part_buffered", 32'(data_out), 32'h03);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_valid_out", 32'(valid_out), 32'd0);
        checkOutput("midrst_pkt_count", 32'(pkt_count), 32'd0);
        checkOutput("midrst_ready_in",  32'(ready_in),  32'd1);
        checkOutput("midrst_data_out",  32'(data_out),  32'hA5);
        outQ.delete();
        applyStimulus(1'b1, 8'h09, 1'b1);
        applyStimulus(1'b1, 8'h09, 1'b1);
        applyStimulus(1'b1, 8'h09, 1'b1);
        applyStimulus(1'b1, 8'h09, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        waitOutputs("rst", 6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("rst[%0d]", i), outAt(i), 32'(expRst[i]));
        checkOutput("rst_pkt_count_after", 32'(pkt_count), 32'd1);

        $display("[TB] packet counter wrap");
        @(negedge clk);
        force dut.r_pktCount = 16'hFFFF;
        #1;
        release dut.r_pktCount;
        #1;
        checkOutput("cnt_preload", 32'(pkt_count), 32'hFFFF);
        outQ.delete();
        applyStimulus(1'b1, 8'hAA, 1'b1);
        applyStimulus(1'b1, 8'hBB, 1'b1);
        applyStimulus(1'b1, 8'hCC, 1'b1);
        applyStimulus(1'b1, 8'hDD, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        waitOutputs("cnt", 6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("cnt[%0d]", i), outAt(i), 32'(expCnt[i]));
        checkOutput("cnt_wrapped", 32'(pkt_count), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
